// File: rtl/skolem_lshr_sched.sv
// skolem_lshr_sched: round-robin sequencer for the shared 4-bit LSHR Skolem core.
// Two requesters submit (s, t) pairs. The winner's operands drive the external
// combinational core, and its result x is captured and returned on a
// valid/ready response port.
// Build option SKOLEM_LSHR_VERIFY_EN adds the following:
//   - an iterative shift check of x (CHECK state)
//   - a computed rsp_ok
//   - the saturating err_cnt output port
// Without SKOLEM_LSHR_VERIFY_EN, rsp_ok reports 1 on every response.
module skolem_lshr_sched #(
  parameter int W       = 4,
  parameter int RR_INIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_s,
  input  logic [W-1:0] req0_t,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_s,
  input  logic [W-1:0] req1_t,
  output logic [W-1:0] core_s,
  output logic [W-1:0] core_t,
  input  logic [W-1:0] core_x,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_x,
  output logic         rsp_ok
`ifdef SKOLEM_LSHR_VERIFY_EN
  ,
  output logic [7:0]   err_cnt
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EVAL  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]   state;
  logic         prio;
  logic [W-1:0] s_reg;
  logic [W-1:0] t_reg;
  logic [W-1:0] x_reg;
  logic         id_reg;
  logic         ok_reg;
  logic         gnt0;
  logic         gnt1;

`ifdef SKOLEM_LSHR_VERIFY_EN
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] K_MAX = CW'(W);
  localparam logic [W:0]    W_EXT = (W + 1)'(W);

  logic [W-1:0]  sh;
  logic [CW-1:0] cnt;
  logic [CW-1:0] k_load;

  // Shift amounts of W or more clamp to W. The zero-fill shifter already yields
  // zero after W steps, so further steps would only add latency.
  always_comb begin
    k_load = ({1'b0, s_reg} >= W_EXT) ? K_MAX : CW'(s_reg);
  end
`endif

  // Arbitration: a lone requester always wins. On contention, the holder of
  // priority wins. Grants are only visible while idle and out of reset.
  always_comb begin
    gnt0       = req0_valid && (!req1_valid || !prio);
    gnt1       = req1_valid && (!req0_valid || prio);
    req0_ready = !rst && (state == S_IDLE) && gnt0;
    req1_ready = !rst && (state == S_IDLE) && gnt1;
  end

  // Core operands come straight from the captured registers. This keeps them
  // stable for the whole operation.
  assign core_s    = s_reg;
  assign core_t    = t_reg;
  assign rsp_valid = (state == S_RESP);
  assign rsp_id    = id_reg;
  assign rsp_x     = x_reg;
  assign rsp_ok    = ok_reg;

  // Main sequencer: capture, evaluate, optionally verify, then hold the
  // response until it is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      prio   <= 1'(RR_INIT);
      s_reg  <= '0;
      t_reg  <= '0;
      x_reg  <= '0;
      id_reg <= 1'b0;
      ok_reg <= 1'b0;
`ifdef SKOLEM_LSHR_VERIFY_EN
      sh      <= '0;
      cnt     <= '0;
      err_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt0 || gnt1) begin
            s_reg  <= gnt1 ? req1_s : req0_s;
            t_reg  <= gnt1 ? req1_t : req0_t;
            id_reg <= gnt1;
            prio   <= !gnt1;
            state  <= S_EVAL;
          end
        end
        S_EVAL: begin
          x_reg <= core_x;
`ifdef SKOLEM_LSHR_VERIFY_EN
          sh    <= core_x;
          cnt   <= k_load;
          state <= S_CHECK;
`else
          ok_reg <= 1'b1;
          state  <= S_RESP;
`endif
        end
        S_CHECK: begin
`ifdef SKOLEM_LSHR_VERIFY_EN
          if (cnt != '0) begin
            sh  <= sh >> 1;
            cnt <= cnt - CW'(1);
          end else begin
            ok_reg <= (sh == t_reg);
            state  <= S_RESP;
          end
`else
          state <= S_RESP;
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
`ifdef SKOLEM_LSHR_VERIFY_EN
            if (!ok_reg && (err_cnt != 8'hFF)) begin
              err_cnt <= err_cnt + 8'd1;
            end
`endif
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_lshr_sched.sv
// tb_skolem_lshr_sched: directed and randomized checks of the LSHR Skolem
// sequencer. A simple core model and a transaction-level reference are used.
// The bench follows SKOLEM_LSHR_VERIFY_EN the same way the design does.
module tb_skolem_lshr_sched;

  localparam int RR = 0;

  logic       clk;
  logic       rst;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_s;
  logic [3:0] req0_t;
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_s;
  logic [3:0] req1_t;
  logic [3:0] core_s;
  logic [3:0] core_t;
  logic [3:0] core_x;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_x;
  logic       rsp_ok;
`ifdef SKOLEM_LSHR_VERIFY_EN
  logic [7:0] err_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;
  bit mp;
  int merr;

  skolem_lshr_sched #(.W(4), .RR_INIT(RR)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_s     (req0_s),
    .req0_t     (req0_t),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_s     (req1_s),
    .req1_t     (req1_t),
    .core_s     (core_s),
    .core_t     (core_t),
    .core_x     (core_x),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_x      (rsp_x),
    .rsp_ok     (rsp_ok)
`ifdef SKOLEM_LSHR_VERIFY_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the external core: x = t << s truncated, zero when s >= 4
  always_comb begin
    core_x = (core_s >= 4'd4) ? 4'd0 : 4'(core_t << core_s);
  end

  // Absolute time bound so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] modelX(input logic [3:0] s, input logic [3:0] t);
    int v;
    v = int'(t) * (1 << int'(s));
    return 4'(v % 16);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction from presenting the valids through to the response handshake
  task automatic applyStimulus(input bit v0, input bit v1,
                               input logic [3:0] s0, input logic [3:0] t0,
                               input logic [3:0] s1, input logic [3:0] t1,
                               input int hold);
    bit         win;
    logic [3:0] es;
    logic [3:0] et;
    logic [3:0] ex;
    logic       eok;
    int         elat;
    int         lat;
    req0_valid = v0; req0_s = s0; req0_t = t0;
    req1_valid = v1; req1_s = s1; req1_t = t1;
    rsp_ready  = 1'b0;
    #1;
    win = (v0 && v1) ? mp : v1;
    checkOutput("grant_ready0", 32'(req0_ready), 32'(!win));
    checkOutput("grant_ready1", 32'(req1_ready), 32'(win));
    es  = win ? s1 : s0;
    et  = win ? t1 : t0;
    ex  = modelX(es, et);
`ifdef SKOLEM_LSHR_VERIFY_EN
    eok  = ((int'(ex) / (1 << int'(es))) == int'(et));
    elat = ((es < 4'd4) ? int'(es) : 4) + 3;
`else
    eok  = 1'b1;
    elat = 2;
`endif
    mp = !win;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      checkOutput("busy_ready0", 32'(req0_ready), 32'(0));
      checkOutput("busy_ready1", 32'(req1_ready), 32'(0));
      @(negedge clk);
      lat++;
    end
    checkOutput("rsp_latency", 32'(lat), 32'(elat));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(1));
    checkOutput("rsp_id", 32'(rsp_id), 32'(win));
    checkOutput("rsp_x", 32'(rsp_x), 32'(ex));
    checkOutput("rsp_ok", 32'(rsp_ok), 32'(eok));
    checkOutput("core_s", 32'(core_s), 32'(es));
    checkOutput("core_t", 32'(core_t), 32'(et));
    repeat (hold) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(rsp_valid), 32'(1));
      checkOutput("hold_x", 32'(rsp_x), 32'(ex));
      checkOutput("hold_id", 32'(rsp_id), 32'(win));
      checkOutput("hold_ok", 32'(rsp_ok), 32'(eok));
      checkOutput("hold_ready0", 32'(req0_ready), 32'(0));
      checkOutput("hold_ready1", 32'(req1_ready), 32'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    if (!eok && merr < 255) merr++;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("post_rsp_valid", 32'(rsp_valid), 32'(0));
`ifdef SKOLEM_LSHR_VERIFY_EN
    checkOutput("err_cnt", 32'(err_cnt), 32'(merr));
`endif
  endtask

  // Directed sequence followed by randomized traffic
  initial begin
    bit         rv0;
    bit         rv1;
    logic [3:0] rs;
    logic [3:0] rt;
    rst = 1'b1;
    req0_valid = 1'b0; req0_s = '0; req0_t = '0;
    req1_valid = 1'b0; req1_s = '0; req1_t = '0;
    rsp_ready = 1'b0;
    mp   = 1'(RR);
    merr = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready0", 32'(req0_ready), 32'(0));
    checkOutput("rst_ready1", 32'(req1_ready), 32'(0));
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'(0));
    checkOutput("rst_rsp_x", 32'(rsp_x), 32'(0));
    checkOutput("rst_rsp_ok", 32'(rsp_ok), 32'(0));
    checkOutput("rst_core_s", 32'(core_s), 32'(0));
    checkOutput("rst_core_t", 32'(core_t), 32'(0));
`ifdef SKOLEM_LSHR_VERIFY_EN
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'(0));
`endif
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'(0));

    // First contended request goes to RR_INIT (requester 0): s=0, t=5
    applyStimulus(1'b1, 1'b1, 4'd0, 4'd5, 4'd3, 4'd3, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    // Non-invertible target from requester 1
    applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 4'b1000, 0);
    req1_valid = 1'b0;
    // Oversized shift clamps to 4
    applyStimulus(1'b1, 1'b0, 4'd9, 4'd0, 4'd0, 4'd0, 0);
    applyStimulus(1'b1, 1'b0, 4'd9, 4'd1, 4'd0, 4'd0, 0);
    req0_valid = 1'b0;
    // Back-to-back contention alternates grants; last response is held back
    applyStimulus(1'b1, 1'b1, 4'd1, 4'd3, 4'd2, 4'd1, 0);
    applyStimulus(1'b1, 1'b1, 4'd1, 4'd3, 4'd2, 4'd1, 0);
    applyStimulus(1'b1, 1'b1, 4'd3, 4'd1, 4'd0, 4'd7, 0);
    applyStimulus(1'b1, 1'b1, 4'd3, 4'd1, 4'd0, 4'd7, 5);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset while an operation is in flight discards it
    req0_valid = 1'b1; req0_s = 4'd3; req0_t = 4'd2;
    #1;
    checkOutput("midrst_grant", 32'(req0_ready), 32'(1));
    @(posedge clk);
    @(negedge clk);
`ifdef SKOLEM_LSHR_VERIFY_EN
    @(negedge clk);
`endif
    rst = 1'b1;
    req0_valid = 1'b0;
    @(negedge clk);
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("midrst_core_s", 32'(core_s), 32'(0));
    checkOutput("midrst_core_t", 32'(core_t), 32'(0));
    checkOutput("midrst_rsp_x", 32'(rsp_x), 32'(0));
`ifdef SKOLEM_LSHR_VERIFY_EN
    checkOutput("midrst_err_cnt", 32'(err_cnt), 32'(0));
`endif
    rst  = 1'b0;
    mp   = 1'(RR);
    merr = 0;
    repeat (10) begin
      @(negedge clk);
      checkOutput("no_stale_rsp", 32'(rsp_valid), 32'(0));
    end
    applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd2, 4'd3, 0);
    req1_valid = 1'b0;

    // Randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
      rs  = 4'($urandom_range(0, 15));
      rt  = 4'($urandom_range(0, 15));
      applyStimulus(rv0, rv1, rs, rt, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

`ifdef SKOLEM_LSHR_VERIFY_EN
    // Error counter saturation: clear it, then force 256 failing responses
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    mp   = 1'(RR);
    merr = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 1'b0, 4'd1, 4'b1000, 4'd0, 4'd0, 0);
    end
    req0_valid = 1'b0;
    checkOutput("err_cnt_sat", 32'(err_cnt), 32'(255));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
